sram_dut_fault: RTL

//  Responder end of the MBIST-to-SRAM interface: single-port 2^AW x DW SRAM model that executes

---
 rtl/sram_dut_pkg.sv | 13 +
 rtl/sram_fault_inj.sv | 55 +++++
 rtl/sram_dut_fault.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sram_dut_pkg.sv
// Shared fault-type codes and FSM state encoding for the MBIST responder SRAM model.
package sram_dut_pkg;
  localparam logic [2:0] FLT_SA0   = 3'd0;
  localparam logic [2:0] FLT_SA1   = 3'd1;
  localparam logic [2:0] FLT_TF_UP = 3'd2;
  localparam logic [2:0] FLT_TF_DN = 3'd3;
  localparam logic [2:0] FLT_CFIN  = 3'd4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/sram_fault_inj.sv
// Single-fault injector: rewrites the write word, read word and coupling victim word.
// Purely combinational; no flow control of its own.
import sram_dut_pkg::*;

module sram_fault_inj #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          flt_en,
  input  logic [2:0]    flt_type,
  input  logic [AW-1:0] flt_addr,
  input  logic [2:0]    flt_bit,
  input  logic [AW-1:0] flt_agg_addr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] cur_word,
  input  logic [DW-1:0] vic_word,
  output logic [DW-1:0] wr_word,
  output logic [DW-1:0] rd_word,
  output logic          cpl_vld,
  output logic [DW-1:0] cpl_word
);
  logic [DW-1:0] mask;
  logic          hit;
  logic          cur_b;
  logic          din_b;

  always_comb begin
    mask     = {{(DW-1){1'b0}}, 1'b1} << flt_bit;
    hit      = flt_en && (addr == flt_addr);
    cur_b    = |(cur_word & mask);
    din_b    = |(din & mask);
    wr_word  = din;
    rd_word  = cur_word;
    cpl_word = vic_word ^ mask;
    // Coupling only fires on a rising aggressor bit; a self-coupled config is inert.
    cpl_vld  = flt_en && (flt_type == FLT_CFIN) && (addr == flt_agg_addr) &&
               (flt_agg_addr != flt_addr) && !cur_b && din_b;
    if (hit) begin
      case (flt_type)
        FLT_SA0: begin
          wr_word = din & ~mask;
          rd_word = cur_word & ~mask;
        end
        FLT_SA1: begin
          wr_word = din | mask;
          rd_word = cur_word | mask;
        end
        FLT_TF_UP: if (!cur_b && din_b) wr_word = din & ~mask;
        FLT_TF_DN: if (cur_b && !din_b) wr_word = din | mask;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sram_dut_fault.sv
// MBIST responder SRAM with post-reset clear sweep and a programmable single-fault injector.
// Reads return on DATA_DUT one cycle after the strobe; accesses are dropped until READY.
import sram_dut_pkg::*;

module sram_dut_fault #(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter int            CNT_W    = 16,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             iWrite,
  input  logic             iRead,
  input  logic [AW-1:0]    ADDR,
  input  logic [DW-1:0]    DATAIN,
  output logic [DW-1:0]    DATA_DUT,
  output logic             READY,
  input  logic             FLT_LD,
  input  logic             FLT_EN,
  input  logic [2:0]       FLT_TYPE,
  input  logic [AW-1:0]    FLT_ADDR,
  input  logic [2:0]       FLT_BIT,
  input  logic [AW-1:0]    FLT_AGG_ADDR,
  output logic [CNT_W-1:0] WR_CNT,
  output logic [CNT_W-1:0] RD_CNT
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  state_t        state;
  logic [AW-1:0] ptr;

  logic          cfg_en;
  logic [2:0]    cfg_type;
  logic [AW-1:0] cfg_addr;
  logic [2:0]    cfg_bit;
  logic [AW-1:0] cfg_agg;

  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;
  logic          cpl_vld;
  logic [DW-1:0] cpl_word;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = (state == ST_RUN) && iWrite;
  assign do_rd = (state == ST_RUN) && iRead && !iWrite;

  sram_fault_inj #(.AW(AW), .DW(DW)) u_inj (
    .flt_en       (cfg_en),
    .flt_type     (cfg_type),
    .flt_addr     (cfg_addr),
    .flt_bit      (cfg_bit),
    .flt_agg_addr (cfg_agg),
    .addr         (ADDR),
    .din          (DATAIN),
    .cur_word     (mem[ADDR]),
    .vic_word     (mem[cfg_addr]),
    .wr_word      (wr_word),
    .rd_word      (rd_word),
    .cpl_vld      (cpl_vld),
    .cpl_word     (cpl_word)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_INIT;
      ptr   <= '0;
      READY <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + AW'(1);
          if (ptr == '1) begin
            state <= ST_RUN;
            READY <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; the sweep clears it. Aggressor and victim never alias here.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT) begin
      mem[ptr] <= INIT_VAL;
    end else if (do_wr) begin
      mem[ADDR] <= wr_word;
      if (cpl_vld) mem[cfg_addr] <= cpl_word;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cfg_en   <= 1'b0;
      cfg_type <= '0;
      cfg_addr <= '0;
      cfg_bit  <= '0;
      cfg_agg  <= '0;
    end else if (FLT_LD) begin
      cfg_en   <= FLT_EN;
      cfg_type <= FLT_TYPE;
      cfg_addr <= FLT_ADDR;
      cfg_bit  <= FLT_BIT;
      cfg_agg  <= FLT_AGG_ADDR;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      DATA_DUT <= '0;
      WR_CNT   <= '0;
      RD_CNT   <= '0;
    end else begin
      if (do_rd) DATA_DUT <= rd_word;
      if (do_wr && (WR_CNT != '1)) WR_CNT <= WR_CNT + CNT_W'(1);
      if (do_rd && (RD_CNT != '1)) RD_CNT <= RD_CNT + CNT_W'(1);
    end
  end
endmodule
